// File: rtl/pm_ram_loader.sv
// rtl/pm_ram_loader.sv - program memory with synchronous fetch and big-endian byte-stream loader
module pm_ram_loader #(
    parameter int                     MEM_SIZE    = 2048,
    parameter int                     ADDR_LENGTH = 11,
    parameter int                     DATA_LENGTH = 16,
    parameter int                     BYTE_WIDTH  = 8,
    parameter logic [DATA_LENGTH-1:0] HALT_WORD   = '0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [ADDR_LENGTH-1:0] i_Addr,
    input  logic                   i_RdEn,
    output logic [DATA_LENGTH-1:0] o_Data,
    input  logic                   i_LoadStart,
    input  logic [BYTE_WIDTH-1:0]  i_Byte,
    input  logic                   i_ByteValid,
    output logic                   o_Loading,
    output logic                   o_Done,
    output logic                   o_Overflow,
    output logic [ADDR_LENGTH:0]   o_WordCount
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_HI,
        ST_LOAD_LO,
        ST_DONE
    } state_t;

    localparam int                     IDX_W      = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_LENGTH:0]   MEM_SIZE_W = (ADDR_LENGTH+1)'(MEM_SIZE);
    localparam logic [ADDR_LENGTH-1:0] LAST_PTR   = ADDR_LENGTH'(MEM_SIZE - 1);

    logic [DATA_LENGTH-1:0] mem [MEM_SIZE];

    state_t                 state_q, state_d;
    logic [ADDR_LENGTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [BYTE_WIDTH-1:0]  hi_q, hi_d;
    logic [ADDR_LENGTH:0]   count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   mem_we;
    logic [DATA_LENGTH-1:0] mem_wdata;
    logic [DATA_LENGTH-1:0] data_q;

    assign o_Data      = data_q;
    assign o_Overflow  = ovf_q;
    assign o_WordCount = count_q;

    // Loader next-state logic: assemble high/low byte pairs into words and stop on the halt marker or a full memory
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        hi_d      = hi_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_wdata = {hi_q, i_Byte};
        o_Loading = 1'b0;
        o_Done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A byte arriving alongside the start pulse is deliberately dropped
                if (i_LoadStart) begin
                    state_d  = ST_LOAD_HI;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                end
            end
            ST_LOAD_HI: begin
                o_Loading = 1'b1;
                if (i_ByteValid) begin
                    hi_d    = i_Byte;
                    state_d = ST_LOAD_LO;
                end
            end
            ST_LOAD_LO: begin
                o_Loading = 1'b1;
                if (i_ByteValid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                    // The halt marker takes priority even when it lands in the last slot
                    if (mem_wdata == HALT_WORD) begin
                        state_d = ST_DONE;
                    end else if (wr_ptr_q == LAST_PTR) begin
                        state_d = ST_IDLE;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = ST_LOAD_HI;
                    end
                end
            end
            ST_DONE: begin
                o_Done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Loader state registers; reset abandons any partial word but leaves memory intact
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            hi_q     <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            hi_q     <= hi_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Instruction store write port; contents survive reset
    always_ff @(posedge i_clk) begin
        if (mem_we && !i_reset) begin
            mem[wr_ptr_q[IDX_W-1:0]] <= mem_wdata;
        end
    end

    // Registered fetch port; feeds NOPs to the CPU while a download is in progress
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q <= '0;
        end else if (state_q != ST_IDLE) begin
            data_q <= '0;
        end else if (i_RdEn) begin
            if ({1'b0, i_Addr} < MEM_SIZE_W) begin
                data_q <= mem[i_Addr[IDX_W-1:0]];
            end else begin
                data_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pm_ram_loader.sv
// tb/tb_pm_ram_loader.sv - directed scoreboard bench for pm_ram_loader (MEM_SIZE=4)
module tb_pm_ram_loader;

    localparam int AL = 11;
    localparam int DL = 16;
    localparam int BW = 8;
    localparam int MS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AL-1:0] addr;
    logic          rd_en;
    logic [DL-1:0] data;
    logic          load_start;
    logic [BW-1:0] byte_in;
    logic          byte_valid;
    logic          loading;
    logic          done;
    logic          overflow;
    logic [AL:0]   word_count;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int done_before;

    logic [DL-1:0] model [MS];
    int            model_ptr;
    logic [DL-1:0] sb [$];

    pm_ram_loader #(
        .MEM_SIZE(MS), .ADDR_LENGTH(AL), .DATA_LENGTH(DL), .BYTE_WIDTH(BW), .HALT_WORD(16'h0000)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_Addr(addr), .i_RdEn(rd_en), .o_Data(data),
        .i_LoadStart(load_start), .i_Byte(byte_in), .i_ByteValid(byte_valid),
        .o_Loading(loading), .o_Done(done), .o_Overflow(overflow), .o_WordCount(word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [BW-1:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            tick();
            check("gap_loading", 32'(loading), 32'd1);
            check("gap_nop", 32'(data), 32'd0);
        end
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [DL-1:0] w, input int gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
        model[model_ptr] = w;
        model_ptr++;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        model_ptr  = 0;
    endtask

    task automatic fetch(input logic [AL-1:0] a);
        sb.push_back((a < MS) ? model[a] : '0);
        addr  = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("fetch", 32'(data), 32'(sb.pop_front()));
    endtask

    initial begin
        rst = 1'b1; addr = '0; rd_en = 1'b1; load_start = 1'b0;
        byte_in = '0; byte_valid = 1'b0; model_ptr = 0;
        for (int i = 0; i < MS; i++) model[i] = '0;

        // Reset state
        tick(); tick();
        rst = 1'b0; rd_en = 1'b0;
        check("rst_data", 32'(data), 32'd0);
        check("rst_loading", 32'(loading), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_wc", 32'(word_count), 32'd0);

        // Back-to-back load terminated by halt word
        start_load();
        check("t2_loading", 32'(loading), 32'd1);
        done_before = done_cnt;
        send_word(16'h1234, 0);
        send_word(16'hABCD, 0);
        send_word(16'h0000, 0);
        check("t2_done", 32'(done), 32'd1);
        check("t2_wc", 32'(word_count), 32'd3);
        tick();
        check("t2_done_low", 32'(done), 32'd0);
        check("t2_idle", 32'(loading), 32'd0);
        check("t2_done_once", 32'(done_cnt - done_before), 32'd1);
        fetch(0); fetch(2); fetch(5); fetch(1);

        // Same program with idle gaps between bytes
        start_load();
        send_word(16'h1234, 5);
        send_word(16'hABCD, 5);
        send_word(16'h0000, 5);
        check("t3_done", 32'(done), 32'd1);
        tick();
        fetch(0); fetch(1); fetch(2);

        // Fill memory without a halt word
        start_load();
        done_before = done_cnt;
        send_word(16'h1111, 0);
        send_word(16'h2222, 0);
        send_word(16'h3333, 0);
        send_word(16'h4444, 0);
        check("t4_ovf", 32'(overflow), 32'd1);
        check("t4_idle", 32'(loading), 32'd0);
        check("t4_wc", 32'(word_count), 32'd4);
        tick();
        check("t4_no_done", 32'(done_cnt - done_before), 32'd0);
        fetch(0); fetch(1); fetch(2); fetch(3);
        start_load();
        check("t4_ovf_clr", 32'(overflow), 32'd0);
        check("t4_wc_clr", 32'(word_count), 32'd0);

        // Reset in the middle of a load
        send_word(16'h5A5A, 0);
        send_byte(8'h77, 0);
        check("t5_wc_pre", 32'(word_count), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_idle", 32'(loading), 32'd0);
        check("t5_wc", 32'(word_count), 32'd0);
        fetch(0); fetch(1);

        // Start pulse with a byte is dropped; start pulse inside LOAD_LO is ignored
        load_start = 1'b1; byte_valid = 1'b1; byte_in = 8'hFF;
        tick();
        load_start = 1'b0; byte_valid = 1'b0; model_ptr = 0;
        send_byte(8'h9A, 0);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("t6_loading", 32'(loading), 32'd1);
        send_byte(8'hBC, 0);
        model[0] = 16'h9ABC; model_ptr = 1;
        check("t6_wc1", 32'(word_count), 32'd1);
        send_word(16'hDEF0, 0);
        send_word(16'h0000, 0);
        check("t6_done", 32'(done), 32'd1);
        check("t6_wc", 32'(word_count), 32'd3);
        tick();
        fetch(0); fetch(1); fetch(2); fetch(3);

        // Halt word landing in the last slot
        start_load();
        send_word(16'h0101, 0);
        send_word(16'h0202, 0);
        send_word(16'h0303, 0);
        send_word(16'h0000, 0);
        check("t7_done", 32'(done), 32'd1);
        check("t7_ovf", 32'(overflow), 32'd0);
        check("t7_wc", 32'(word_count), 32'd4);
        tick();
        fetch(3); fetch(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
